// File: rtl/camera_cmd_tx_if.sv
// Command and UART-transmit signal bundle for camera_cmd_tx.
// slave = the command sender; master = controller plus UART side.
interface camera_cmd_tx_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [15:0] cmd_addr;
    logic [15:0] cmd_len;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        tx_busy;
    logic        done;
    logic        err;

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_len, tx_busy,
        output cmd_ready, tx_data, tx_wr, done, err
    );

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_len, tx_busy,
        input  cmd_ready, tx_data, tx_wr, done, err
    );
endinterface

// File: rtl/camera_cmd_tx.sv
// LS-Y201 command sender: serialises one camera command into the UART
// transmitter, one byte per frame, with an optional ack timeout.
module camera_cmd_tx #(
    parameter logic [15:0] INTERVAL    = 16'h000A,
    parameter logic [15:0] ACK_TIMEOUT = 16'd1024
) (
    input  logic            clk,
    input  logic            reset,
    camera_cmd_tx_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_HI,
        S_WAIT_LO
    } state_t;

    state_t      state, state_n;
    logic [2:0]  op_q, op_n;
    logic [15:0] addr_q, addr_n;
    logic [15:0] len_q, len_n;
    logic [3:0]  idx, idx_n;
    logic [15:0] timer, timer_n;
    logic [7:0]  tx_data_q, tx_data_n;
    logic        tx_wr_q, tx_wr_n;
    logic        done_q, done_n;
    logic        err_q, err_n;

    function automatic logic [3:0] last_idx(input logic [2:0] op);
        case (op)
            3'd0:    last_idx = 4'd3;
            3'd3:    last_idx = 4'd15;
            default: last_idx = 4'd4;
        endcase
    endfunction

    function automatic logic [7:0] cmd_byte(input logic [2:0]  op,
                                            input logic [3:0]  i,
                                            input logic [15:0] a,
                                            input logic [15:0] l);
        cmd_byte = 8'h00;
        case (i)
            4'd0: cmd_byte = 8'h56;
            4'd2: begin
                case (op)
                    3'd0:    cmd_byte = 8'h26;
                    3'd2:    cmd_byte = 8'h34;
                    3'd3:    cmd_byte = 8'h32;
                    default: cmd_byte = 8'h36;
                endcase
            end
            4'd3: begin
                case (op)
                    3'd0:    cmd_byte = 8'h00;
                    3'd3:    cmd_byte = 8'h0C;
                    default: cmd_byte = 8'h01;
                endcase
            end
            4'd4:  cmd_byte = (op == 3'd4) ? 8'h03 : 8'h00;
            4'd5:  cmd_byte = 8'h0A;
            4'd8:  cmd_byte = a[15:8];
            4'd9:  cmd_byte = a[7:0];
            4'd12: cmd_byte = l[15:8];
            4'd13: cmd_byte = l[7:0];
            4'd14: cmd_byte = INTERVAL[15:8];
            4'd15: cmd_byte = INTERVAL[7:0];
            default: cmd_byte = 8'h00;
        endcase
    endfunction

    always_comb begin
        state_n   = state;
        op_n      = op_q;
        addr_n    = addr_q;
        len_n     = len_q;
        idx_n     = idx;
        timer_n   = timer;
        tx_data_n = tx_data_q;
        tx_wr_n   = 1'b0;
        done_n    = 1'b0;
        err_n     = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    op_n   = bus.cmd_op;
                    addr_n = bus.cmd_addr;
                    len_n  = bus.cmd_len;
                    idx_n  = '0;
                    if (bus.cmd_op <= 3'd4) state_n = S_SEND;
                    else                    err_n   = 1'b1;
                end
            end
            S_SEND: begin
                if (!bus.tx_busy) begin
                    tx_data_n = cmd_byte(op_q, idx, addr_q, len_q);
                    tx_wr_n   = 1'b1;
                    timer_n   = '0;
                    state_n   = S_WAIT_HI;
                end
            end
            S_WAIT_HI: begin
                if (bus.tx_busy) begin
                    state_n = S_WAIT_LO;
                end else begin
                    timer_n = timer + 16'd1;
                    // Abandon the rest of the command if the UART never acknowledges.
                    if ((ACK_TIMEOUT != 16'd0) && (timer_n == ACK_TIMEOUT)) begin
                        err_n   = 1'b1;
                        state_n = S_IDLE;
                    end
                end
            end
            S_WAIT_LO: begin
                if (!bus.tx_busy) begin
                    if (idx == last_idx(op_q)) begin
                        done_n  = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        idx_n   = idx + 4'd1;
                        state_n = S_SEND;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            op_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            idx       <= '0;
            timer     <= '0;
            tx_data_q <= '0;
            tx_wr_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_n;
            op_q      <= op_n;
            addr_q    <= addr_n;
            len_q     <= len_n;
            idx       <= idx_n;
            timer     <= timer_n;
            tx_data_q <= tx_data_n;
            tx_wr_q   <= tx_wr_n;
            done_q    <= done_n;
            err_q     <= err_n;
        end
    end

    assign bus.cmd_ready = (state == S_IDLE);
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_wr     = tx_wr_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_camera_cmd_tx.sv
// Bench for camera_cmd_tx: directed scenarios plus random commands checked
// against a byte-list model of the LS-Y201 command set.
module tb_camera_cmd_tx;

    localparam logic [15:0] INTERVAL = 16'h000A;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic reset;
    camera_cmd_tx_if bus();

    camera_cmd_tx #(.INTERVAL(INTERVAL), .ACK_TIMEOUT(16'd8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // UART model: goes busy on the edge after a strobe, stays busy busy_len cycles.
    logic uart_en  = 1'b1;
    int   busy_len = 10;
    int   busy_cnt = 0;
    always @(posedge clk) begin
        if (bus.tx_busy === 1'bx) begin
            bus.tx_busy <= 1'b0;
        end else if (uart_en && bus.tx_wr && !bus.tx_busy) begin
            bus.tx_busy <= 1'b1;
            busy_cnt    <= busy_len;
        end else if (bus.tx_busy) begin
            if (busy_cnt <= 1) bus.tx_busy <= 1'b0;
            else               busy_cnt    <= busy_cnt - 1;
        end
    end

    bq_t got;
    int  cyc = 0, wr_cyc = 0, err_cyc = 0;
    int  done_cnt = 0, err_cnt = 0, both_cnt = 0;
    always @(posedge clk) begin
        cyc++;
        if (reset === 1'b1) begin
            if (bus.tx_wr) begin got.push_back(bus.tx_data); wr_cyc = cyc; end
            if (bus.done) done_cnt++;
            if (bus.err) begin err_cnt++; err_cyc = cyc; end
            if (bus.done && bus.err) both_cnt++;
        end
    end

    function automatic bq_t model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] l);
        bq_t q;
        if (op > 3'd4) return q;
        q.push_back(8'h56); q.push_back(8'h00);
        case (op)
            3'd0: begin q.push_back(8'h26); q.push_back(8'h00); end
            3'd1: begin q.push_back(8'h36); q.push_back(8'h01); q.push_back(8'h00); end
            3'd2: begin q.push_back(8'h34); q.push_back(8'h01); q.push_back(8'h00); end
            3'd4: begin q.push_back(8'h36); q.push_back(8'h01); q.push_back(8'h03); end
            default: begin
                q.push_back(8'h32); q.push_back(8'h0C); q.push_back(8'h00); q.push_back(8'h0A);
                q.push_back(8'h00); q.push_back(8'h00); q.push_back(a[15:8]); q.push_back(a[7:0]);
                q.push_back(8'h00); q.push_back(8'h00); q.push_back(l[15:8]); q.push_back(l[7:0]);
                q.push_back(INTERVAL[15:8]); q.push_back(INTERVAL[7:0]);
            end
        endcase
        return q;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_bytes(input string tag, input bq_t exp);
        logic [7:0] g;
        check({tag, "_count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            g = (i < got.size()) ? got[i] : 8'hxx;
            check($sformatf("%s_byte%0d", tag, i), g, exp[i]);
        end
    endtask

    task automatic scramble();
        bus.cmd_op   = 3'($urandom);
        bus.cmd_addr = 16'($urandom);
        bus.cmd_len  = 16'($urandom);
    endtask

    task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] l);
        @(negedge clk);
        bus.cmd_op = op; bus.cmd_addr = a; bus.cmd_len = l; bus.cmd_valid = 1'b1;
        check("ready_idle", bus.cmd_ready, 1'b1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        scramble();
    endtask

    task automatic wait_end(input int d0, input int e0, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done_cnt != d0 || err_cnt != e0) begin ok = 1'b1; break; end
            scramble();
        end
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [15:0] a, input logic [15:0] l, input string tag);
        int d0, e0; bit ok; bq_t exp;
        exp = model(op, a, l);
        got.delete(); d0 = done_cnt; e0 = err_cnt;
        issue(op, a, l);
        wait_end(d0, e0, ok);
        check({tag, "_finished"}, ok, 1'b1);
        repeat (2) @(negedge clk);
        check_bytes(tag, exp);
        check({tag, "_done"}, done_cnt - d0, (op <= 3'd4) ? 1 : 0);
        check({tag, "_err"},  err_cnt - e0,  (op <= 3'd4) ? 0 : 1);
    endtask

    initial begin
        int d0, e0, d1; bit ok, found;
        bq_t exp, exp2;
        logic [2:0] sop; logic [15:0] sa, sl, a1, l1;

        reset = 1'b0; bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_addr = '0; bus.cmd_len = '0;
        repeat (3) @(negedge clk);
        check("rst_ready",   bus.cmd_ready, 1'b1);
        check("rst_tx_wr",   bus.tx_wr,     1'b0);
        check("rst_tx_data", bus.tx_data,   8'h00);
        check("rst_done",    bus.done,      1'b0);
        check("rst_err",     bus.err,       1'b0);
        reset = 1'b1;

        // RESET op with first-strobe latency
        got.delete(); d0 = done_cnt; e0 = err_cnt;
        issue(3'd0, 16'h0, 16'h0);
        @(negedge clk); check("t1_wr_T", bus.tx_wr, 1'b0);
        @(negedge clk); check("t1_wr_T1", bus.tx_wr, 1'b1); check("t1_data_T1", bus.tx_data, 8'h56);
        wait_end(d0, e0, ok);
        check("t1_finished", ok, 1'b1);
        repeat (2) @(negedge clk);
        check_bytes("t1", model(3'd0, 16'h0, 16'h0));
        check("t1_done", done_cnt - d0, 1);
        check("t1_err",  err_cnt - e0, 0);

        run_cmd(3'd3, 16'h1234, 16'h0020, "t2_read_data");

        // ack timeout: UART never goes busy
        uart_en = 1'b0;
        got.delete(); d0 = done_cnt; e0 = err_cnt;
        issue(3'd1, 16'h0, 16'h0);
        wait_end(d0, e0, ok);
        check("t3_finished", ok, 1'b1);
        repeat (2) @(negedge clk);
        check("t3_wr_count", got.size(), 1);
        check("t3_byte0", (got.size() > 0) ? got[0] : 8'hxx, 8'h56);
        check("t3_err", err_cnt - e0, 1);
        check("t3_done", done_cnt - d0, 0);
        check("t3_err_delay", err_cyc - wr_cyc, 8);
        check("t3_ready", bus.cmd_ready, 1'b1);
        uart_en = 1'b1;

        // illegal opcode
        got.delete(); d0 = done_cnt; e0 = err_cnt;
        issue(3'd6, 16'h0, 16'h0);
        @(negedge clk);
        check("t4_err_pulse", bus.err, 1'b1);
        check("t4_ready", bus.cmd_ready, 1'b1);
        @(negedge clk);
        check("t4_err_gone", bus.err, 1'b0);
        repeat (4) @(negedge clk);
        check("t4_no_wr", got.size(), 0);
        check("t4_no_done", done_cnt - d0, 0);

        // reset during TAKE_PIC, on the third strobe
        got.delete();
        issue(3'd1, 16'h0, 16'h0);
        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            @(negedge clk);
            if (got.size() >= 2 && bus.tx_wr) found = 1'b1;
        end
        check("t5_third_strobe", found, 1'b1);
        check("t5_third_data", bus.tx_data, 8'h36);
        reset = 1'b0; #1;
        check("t5_rst_wr", bus.tx_wr, 1'b0);
        check("t5_rst_data", bus.tx_data, 8'h00);
        check("t5_rst_ready", bus.cmd_ready, 1'b1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        run_cmd(3'd4, 16'h0, 16'h0, "t5_stop_pic");

        // cmd_valid held with changing inputs; second command taken on the done cycle
        got.delete(); d0 = done_cnt; e0 = err_cnt;
        a1 = 16'($urandom); l1 = 16'($urandom);
        @(negedge clk);
        bus.cmd_op = 3'd2; bus.cmd_addr = a1; bus.cmd_len = l1; bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            bus.cmd_op = 3'($urandom_range(0, 4)); bus.cmd_addr = 16'($urandom); bus.cmd_len = 16'($urandom);
            @(negedge clk);
            if (bus.done) begin found = 1'b1; break; end
        end
        check("t6_done_seen", found, 1'b1);
        check("t6_ready_on_done", bus.cmd_ready, 1'b1);
        sop = bus.cmd_op; sa = bus.cmd_addr; sl = bus.cmd_len;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        d1 = done_cnt;
        wait_end(d1, e0, ok);
        check("t6_second_finished", ok, 1'b1);
        repeat (2) @(negedge clk);
        exp = model(3'd2, a1, l1);
        exp2 = model(sop, sa, sl);
        foreach (exp2[i]) exp.push_back(exp2[i]);
        check_bytes("t6", exp);
        check("t6_done", done_cnt - d0, 2);

        // random commands, varying UART frame length
        for (int n = 0; n < 20; n++) begin
            logic [2:0] rop;
            busy_len = $urandom_range(1, 12);
            rop = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            run_cmd(rop, 16'($urandom), 16'($urandom), $sformatf("rnd%0d", n));
        end

        check("never_done_and_err", both_cnt, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
